// File: rtl/rf_pkg.sv
// Shared register-file types for decode, writeback and the register file itself.
package rf_pkg;

  localparam int RF_ADDR_WIDTH = 5;
  localparam int RF_DATA_WIDTH = 32;

  typedef logic [RF_ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [RF_DATA_WIDTH-1:0] rf_data_t;

  // Architectural x0; hardwired to zero when the file is built with ZERO_REG=1.
  localparam rf_addr_t ZERO_ADDR = '0;

endpackage

// File: rtl/rf_mp_if.sv
// Decode/writeback-facing bundle of the multi-port register file.
// The master side (pipeline) drives writes, reads and reservations; the
// slave side (rf_mp) returns read data, busy flags and the busy count.
interface rf_mp_if
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATAWIDTH  = RF_DATA_WIDTH,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 1
);

  // Writeback ports
  logic [NWRITE-1:0]                 wen;
  logic [NWRITE-1:0][ADDR_WIDTH-1:0] waddr;
  logic [NWRITE-1:0][DATAWIDTH-1:0]  wdata;

  // Decode read ports
  logic [NREAD-1:0][ADDR_WIDTH-1:0]  rR;
  logic [NREAD-1:0][DATAWIDTH-1:0]   rR_data;
  logic [NREAD-1:0]                  rR_busy;

  // Destination reservation for issued instructions
  logic                              rsv_en;
  logic [ADDR_WIDTH-1:0]             rsv_addr;
  logic [ADDR_WIDTH:0]               busy_cnt;

  modport master (
    output wen, waddr, wdata, rR, rsv_en, rsv_addr,
    input  rR_data, rR_busy, busy_cnt
  );

  modport slave (
    input  wen, waddr, wdata, rR, rsv_en, rsv_addr,
    output rR_data, rR_busy, busy_cnt
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a running count of
// reserved registers. Reservations set bits, writebacks clear them, and a
// reservation landing on the same edge as a clear of the same register wins.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              rsv_en,
  input  logic [ADDR_WIDTH-1:0]             rsv_addr,
  input  logic [NWRITE-1:0]                 clr_en,
  input  logic [NWRITE-1:0][ADDR_WIDTH-1:0] clr_addr,
  input  logic [NREAD-1:0][ADDR_WIDTH-1:0]  lookup_addr,
  output logic [NREAD-1:0]                  lookup_busy,
  output logic [ADDR_WIDTH:0]               busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

  logic [DEPTH-1:0]    busy;
  logic [DEPTH-1:0]    busy_nxt;
  logic [DEPTH-1:0]    set_vec;
  logic [DEPTH-1:0]    clr_mask;
  logic [DEPTH-1:0]    drop_mask;
  logic                set_ok;
  logic [ADDR_WIDTH:0] dec;
  logic [ADDR_WIDTH:0] inc;
  logic [ADDR_WIDTH:0] cnt_nxt;

  // Qualify the reservation: x0 never reserves when it is hardwired.
  always_comb begin
    set_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == ADDR_WIDTH'(ZERO_ADDR)));
  end

  // Build one-hot set and clear masks; duplicate clear addresses collapse to one bit.
  always_comb begin
    // NOTE: every variable gets a default before the conditional updates so no latch is inferred.
    set_vec  = '0;
    clr_mask = '0;
    if (set_ok) begin
      set_vec[rsv_addr] = 1'b1;
    end
    for (int p = 0; p < NWRITE; p++) begin
      if (clr_en[p]) begin
        clr_mask[clr_addr[p]] = 1'b1;
      end
    end
  end

  // Next busy vector and incremental count: a clear only counts when the bit
  // is set now and is not being re-reserved on the same edge.
  always_comb begin
    busy_nxt  = (busy & ~clr_mask) | set_vec;
    drop_mask = busy & clr_mask & ~set_vec;
    dec       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (drop_mask[i]) begin
        dec = dec + CNT_ONE;
      end
    end
    inc     = (set_ok && !busy[rsv_addr]) ? CNT_ONE : '0;
    cnt_nxt = busy_cnt + inc - dec;
  end

  // Scoreboard state; reset dominates any same-edge reserve or clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  // Per-read-port lookup of the stored busy bit (no same-cycle clear forwarding).
  always_comb begin
    lookup_busy = '0;
    for (int r = 0; r < NREAD; r++) begin
      lookup_busy[r] = busy[lookup_addr[r]];
    end
  end

endmodule

// File: rtl/rf_mp.sv
// Multi-port register file with optional write-to-read bypass, optional
// hardwired x0 and a pending-write scoreboard used by decode for RAW hazards.
module rf_mp
  import rf_pkg::*;
#(
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int DATAWIDTH  = RF_DATA_WIDTH,
  parameter int NREAD      = 2,
  parameter int NWRITE     = 1,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic      clk,
  input  logic      rst,
  rf_mp_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0 = ADDR_WIDTH'(ZERO_ADDR);

  logic [DATAWIDTH-1:0]             reg_bank [DEPTH];
  logic [NWRITE-1:0]                wr_keep;
  logic [NREAD-1:0][DATAWIDTH-1:0]  rdata;

  // Drop writes to x0 when it is hardwired; the scoreboard still sees every write.
  always_comb begin
    wr_keep = '0;
    for (int p = 0; p < NWRITE; p++) begin
      wr_keep[p] = bus.wen[p] && !((ZERO_REG != 0) && (bus.waddr[p] == X0));
    end
  end

  // Register storage; higher write port wins an address conflict.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: the bank is cleared on reset because software relies on every register reading 0 afterwards; this costs a reset on each flop.
      for (int i = 0; i < DEPTH; i++) begin
        reg_bank[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates in ascending port order, so the last (highest) port's assignment to a shared address is the one that sticks.
      for (int p = 0; p < NWRITE; p++) begin
        if (wr_keep[p]) begin
          reg_bank[bus.waddr[p]] <= bus.wdata[p];
        end
      end
    end
  end

  // Read mux: stored value, optionally overridden by same-cycle write data, then x0 forced to zero.
  always_comb begin
    rdata = '0;
    for (int r = 0; r < NREAD; r++) begin
      rdata[r] = reg_bank[bus.rR[r]];
      if (BYPASS != 0) begin
        for (int p = 0; p < NWRITE; p++) begin
          if (bus.wen[p] && (bus.waddr[p] == bus.rR[r])) begin
            rdata[r] = bus.wdata[p];
          end
        end
      end
      if ((ZERO_REG != 0) && (bus.rR[r] == X0)) begin
        rdata[r] = '0;
      end
    end
  end

  assign bus.rR_data = rdata;

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NREAD      (NREAD),
    .NWRITE     (NWRITE),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rsv_en      (bus.rsv_en),
    .rsv_addr    (bus.rsv_addr),
    .clr_en      (bus.wen),
    .clr_addr    (bus.waddr),
    .lookup_addr (bus.rR),
    .lookup_busy (bus.rR_busy),
    .busy_cnt    (bus.busy_cnt)
  );

endmodule

// File: doc/rf_mp.md
# rf_mp

Multi-port, parametrised register file for the pipelined MINIRISC-V core. It replaces the fixed 2-read/1-write register file. It adds configurable read and write port counts, optional same-cycle write-to-read bypass, an optional hardwired-zero x0, and a per-register pending-write scoreboard. Decode uses the scoreboard to detect RAW hazards. The block sits between decode (reads, reservations) and writeback (writes).

## Interface
- `ADDR_WIDTH`, 5: register address width; depth = 2**ADDR_WIDTH.
- `DATAWIDTH`, 32: register width.
- `NREAD`, 2: number of read ports, 1..4.
- `NWRITE`, 1: number of write ports, 1..2.
- `BYPASS`, 1: 1 = a read returns same-cycle write data; 0 = read returns stored value.
- `ZERO_REG`, 1: 1 = entry 0 reads 0, ignores writes, never reserves.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-low; all state cleared on a rising `clk` while `rst`=0.
- `wen` in NWRITE: per-port write enable.
- `waddr` in NWRITE×ADDR_WIDTH: packed array of write addresses.
- `wdata` in NWRITE×DATAWIDTH: packed array of write data.
- `rR` in NREAD×ADDR_WIDTH: packed array of read addresses.
- `rR_data` out NREAD×DATAWIDTH: read data, combinational.
- `rR_busy` out NREAD: addressed register has a pending reservation, combinational.
- `rsv_en` in 1: reserve a destination register (issued instruction).
- `rsv_addr` in ADDR_WIDTH: register to reserve.
- `busy_cnt` out ADDR_WIDTH+1: number of currently reserved registers, registered.

## Operation
- Storage: `reg_bank[2**ADDR_WIDTH]`; `busy[2**ADDR_WIDTH]` bit vector; `busy_cnt` counter.
- Write: on each rising `clk` with `rst`=1, every port p with `wen[p]` updates `reg_bank[waddr[p]]` ← `wdata[p]`. With ZERO_REG=1, writes to address 0 are dropped.
- Write conflict: two ports writing the same address in one cycle → the higher port index wins.
- Read: `rR_data[r]` = 0 if ZERO_REG and `rR[r]`=0. Otherwise, with BYPASS=1 and a matching active write port, it returns that port's `wdata` (highest index wins). Otherwise it returns `reg_bank[rR[r]]`.
- Scoreboard set: `rsv_en` sets `busy[rsv_addr]`. This is ignored for address 0 when ZERO_REG=1.
- Scoreboard clear: each active write port clears `busy[waddr[p]]`. A write to a non-busy register is legal and leaves busy at 0.
- Simultaneous reserve and write to the same address: the reserve wins, so busy stays 1 and the data is still written.
- `rR_busy[r]` = `busy[rR[r]]` as currently stored. It does not reflect the same-cycle clear. With BYPASS=1, consumers use the bypassed data regardless.
- `busy_cnt` next value = popcount of next `busy`. It is maintained incrementally: +1 for a set on a non-busy register, −1 for each distinct clear of a busy register. Range is 0..2**ADDR_WIDTH, never wraps.

## Timing
- Reset: every `reg_bank` entry = 0, `busy` = 0, `busy_cnt` = 0. Combinational outputs therefore read 0 and `rR_busy` = 0 after the reset edge.
- A reset edge overrides any concurrent write or reserve.
- Write latency: data is visible through storage on the cycle after the edge, or in the same cycle via bypass when BYPASS=1.
- Reserve latency: `rR_busy` asserts the cycle after the `rsv_en` edge.
- Clear latency: `rR_busy` deasserts the cycle after the write edge.
- There is no handshake; all inputs are sampled every edge.

## Structure
- Package `rf_pkg`: `rf_addr_t`/`rf_data_t` typedefs and the `ZERO_ADDR` constant. Decode and writeback share these.
- Sub-module `rf_scoreboard`: owns `busy` and `busy_cnt`, with reserve/clear inputs and a lookup per read port. `rf_mp` instantiates it alongside the storage/bypass logic.

## Test plan
- Reset: write x5=0xDEADBEEF, then hold `rst`=0 one edge → `rR_data` for x5 = 0, `busy_cnt`=0.
- Bypass: BYPASS=1, write x3=0x1234 while reading x3 → same-cycle `rR_data`=0x1234. With BYPASS=0 the same-cycle read returns the old value, and 0x1234 appears next cycle.
- Zero register: write x0=0xFFFFFFFF plus reserve x0 → x0 reads 0, `rR_busy`=0, `busy_cnt` unchanged. With ZERO_REG=0, x0 reads 0xFFFFFFFF.
- Write conflict: NWRITE=2, both ports write x7 (0xA, 0xB) → x7 reads 0xB.
- Scoreboard: reserve x4, x9 on consecutive cycles → `busy_cnt`=2. Writing x4 → `busy_cnt`=1. Reserving x9 again → `busy_cnt` stays 1.
- Same-edge reserve and write of x6 (x6 busy beforehand) → x6 stays busy, data written, `busy_cnt` unchanged.
